tx_seg_coalesce: RTL and testbench

Consumes TX segment descriptors from the small peek FIFO that buffers send requests and merges runs of sequence-contiguous descriptors into one larger segment before handing them to the segment engine. It sits directly downstream of that FIFO, driving its read request from the FIFO's head data and occupancy count. It presents coalesced segments on a valid/ready interface.

---
 rtl/tx_seg_coalesce_pkg.sv | 22 ++
 rtl/tx_seg_coalesce.sv | 116 +++++++++++
 tb/tb_tx_seg_coalesce.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/tx_seg_coalesce_pkg.sv
// Shared types and default widths for the TX segment coalescer.
package tx_seg_coalesce_pkg;

   localparam int SEQ_W_DEF       = 32;
   localparam int LEN_W_DEF       = 16;
   localparam int MAX_LEN_DEF     = 1460;
   localparam int TIMEOUT_CYC_DEF = 64;
   localparam int ELS_W_DEF       = 2;

   // Sequence in the MSBs to match how the send FIFO packs its entries.
   typedef struct packed {
      logic [SEQ_W_DEF-1:0] seq;
      logic [LEN_W_DEF-1:0] len;
   } seg_entry_t;

   typedef enum logic [1:0] {
      EMPTY,
      ACCUM,
      OUT
   } seg_state_t;

endpackage

// File: rtl/tx_seg_coalesce.sv
// Merges sequence-contiguous TX descriptors from the send FIFO into larger
// segments for the segment engine.
//
// state | meaning
// EMPTY | no accumulation open; load the next head when one appears
// ACCUM | accumulating contiguous descriptors, idle timer running
// OUT   | coalesced segment presented, waiting for seg_rdy
module tx_seg_coalesce
   import tx_seg_coalesce_pkg::*;
#(
   parameter int SEQ_W       = SEQ_W_DEF,
   parameter int LEN_W       = LEN_W_DEF,
   parameter int MAX_LEN     = MAX_LEN_DEF,
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
   parameter int ELS_W       = ELS_W_DEF
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [ELS_W:0]         fifo_num_els,
   input  logic [SEQ_W+LEN_W-1:0] fifo_rd_data,
   output logic                   fifo_rd_req,
   input  logic                   flush,
   output logic                   seg_val,
   output logic [SEQ_W-1:0]       seg_seq,
   output logic [LEN_W-1:0]       seg_len,
   input  logic                   seg_rdy
);

   localparam int IDLE_W = $clog2(TIMEOUT_CYC);

   seg_state_t        state;
   logic [SEQ_W-1:0]  acc_seq;
   logic [LEN_W-1:0]  acc_len;
   logic [IDLE_W-1:0] idle_cnt;

   logic [SEQ_W-1:0]  head_seq;
   logic [LEN_W-1:0]  head_len;
   logic [LEN_W:0]    len_sum;
   logic              head_avail;
   logic              contig;
   logic              fits;
   logic              pop;

   assign head_seq   = fifo_rd_data[SEQ_W+LEN_W-1:LEN_W];
   assign head_len   = fifo_rd_data[LEN_W-1:0];
   assign head_avail = (fifo_num_els != '0);
   assign contig     = ((acc_seq + SEQ_W'(acc_len)) == head_seq);
   assign len_sum    = {1'b0, acc_len} + {1'b0, head_len};
   assign fits       = (len_sum <= (LEN_W+1)'(MAX_LEN));

   always_comb begin
      pop = 1'b0;
      case (state)
         EMPTY:   pop = head_avail;
         ACCUM:   pop = !flush && head_avail && contig && fits;
         OUT:     pop = seg_rdy && head_avail && !flush;
         default: pop = 1'b0;
      endcase
   end

   // State resets to EMPTY asynchronously, but EMPTY with a head would pop,
   // so the request is also gated by reset directly.
   assign fifo_rd_req = pop && rst_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= EMPTY;
         acc_seq  <= '0;
         acc_len  <= '0;
         idle_cnt <= '0;
      end else begin
         case (state)
            EMPTY: begin
               if (head_avail) begin
                  acc_seq  <= head_seq;
                  acc_len  <= head_len;
                  idle_cnt <= '0;
                  state    <= ACCUM;
               end
            end
            ACCUM: begin
               if (flush) begin
                  state <= OUT;
               end else if (head_avail && contig && fits) begin
                  acc_len  <= len_sum[LEN_W-1:0];
                  idle_cnt <= '0;
               end else if (head_avail) begin
                  state <= OUT;
               end else if (idle_cnt == IDLE_W'(TIMEOUT_CYC-1)) begin
                  state <= OUT;
               end else begin
                  idle_cnt <= idle_cnt + 1'b1;
               end
            end
            OUT: begin
               if (seg_rdy) begin
                  if (head_avail && !flush) begin
                     acc_seq  <= head_seq;
                     acc_len  <= head_len;
                     idle_cnt <= '0;
                     state    <= ACCUM;
                  end else begin
                     state <= EMPTY;
                  end
               end
            end
            default: state <= EMPTY;
         endcase
      end
   end

   assign seg_val = (state == OUT);
   assign seg_seq = acc_seq;
   assign seg_len = acc_len;

endmodule

// File: tb/tb_tx_seg_coalesce.sv
// Directed bench for tx_seg_coalesce with a behavioural send-FIFO model.
module tb_tx_seg_coalesce;
   import tx_seg_coalesce_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  fifo_num_els;
   logic [47:0] fifo_rd_data;
   logic        fifo_rd_req;
   logic        flush;
   logic        seg_val;
   logic [31:0] seg_seq;
   logic [15:0] seg_len;
   logic        seg_rdy;

   tx_seg_coalesce dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .fifo_num_els (fifo_num_els),
      .fifo_rd_data (fifo_rd_data),
      .fifo_rd_req  (fifo_rd_req),
      .flush        (flush),
      .seg_val      (seg_val),
      .seg_seq      (seg_seq),
      .seg_len      (seg_len),
      .seg_rdy      (seg_rdy)
   );

   always #5 clk = ~clk;

   seg_entry_t fmem [4];
   int         fcount;
   assign fifo_num_els = 3'(fcount);
   assign fifo_rd_data = fmem[0];

   int         checks;
   int         errors;
   seg_entry_t got_q[$];
   int         edges_since_pop;

   typedef struct {
      string       name;
      int          n_in;
      logic [31:0] iseq [3];
      logic [15:0] ilen [3];
      int          n_out;
      logic [31:0] oseq [2];
      logic [15:0] olen [2];
   } vec_t;

   vec_t vecs [10];

   function automatic vec_t mk(string nm, int ni,
                               logic [31:0] s0, logic [15:0] l0,
                               logic [31:0] s1, logic [15:0] l1,
                               logic [31:0] s2, logic [15:0] l2,
                               int no,
                               logic [31:0] e0s, logic [15:0] e0l,
                               logic [31:0] e1s, logic [15:0] e1l);
      vec_t v;
      v.name = nm;
      v.n_in = ni;
      v.iseq[0] = s0; v.ilen[0] = l0;
      v.iseq[1] = s1; v.ilen[1] = l1;
      v.iseq[2] = s2; v.ilen[2] = l2;
      v.n_out = no;
      v.oseq[0] = e0s; v.olen[0] = e0l;
      v.oseq[1] = e1s; v.olen[1] = e1l;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push(input logic [31:0] s, input logic [15:0] l);
      checks++;
      if (fcount >= 4) begin
         errors++;
         $display("FAIL fifo_push: count %0d expected below 4", fcount);
      end else begin
         fmem[fcount] = {s, l};
         fcount++;
      end
   endtask

   // Called at the falling edge; advances one rising edge and returns at the next falling edge.
   task automatic step();
      bit         pop;
      bit         xfer;
      seg_entry_t cur;
      #1;
      pop  = fifo_rd_req;
      xfer = seg_val && seg_rdy;
      cur  = {seg_seq, seg_len};
      if (fcount == 0) check("rd_req_when_empty", 64'(fifo_rd_req), 64'd0);
      @(posedge clk);
      #1;
      if (xfer) got_q.push_back(cur);
      if (pop && fcount > 0) begin
         for (int i = 0; i < 3; i++) fmem[i] = fmem[i+1];
         fmem[3] = '0;
         fcount--;
         edges_since_pop = 1;
      end else begin
         edges_since_pop++;
      end
      @(negedge clk);
   endtask

   task automatic drain();
      int quiet;
      quiet = 0;
      for (int n = 0; n < 1000 && quiet < 70; n++) begin
         step();
         if (seg_val || fcount != 0) quiet = 0;
         else quiet++;
      end
      checks++;
      if (quiet < 70) begin
         errors++;
         $display("FAIL drain_timeout: quiet %0d expected 70", quiet);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int gap;
      bit seen;
      checks = 0;
      errors = 0;
      fcount = 0;
      edges_since_pop = 0;
      for (int i = 0; i < 4; i++) fmem[i] = '0;
      rst_n   = 1'b0;
      flush   = 1'b0;
      seg_rdy = 1'b1;

      vecs[0] = mk("contig",   3, 100, 10, 110, 20, 130, 5,      1, 100, 35, 0, 0);
      vecs[1] = mk("gap",      2, 100, 10, 200, 10, 0, 0,        2, 100, 10, 200, 10);
      vecs[2] = mk("cap",      2, 0, 1000, 1000, 1000, 0, 0,     2, 0, 1000, 1000, 1000);
      vecs[3] = mk("exact",    2, 0, 1460, 1460, 0, 0, 0,        1, 0, 1460, 0, 0);
      vecs[4] = mk("wrap",     2, 32'hFFFF_FFF0, 16, 0, 8, 0, 0, 1, 32'hFFFF_FFF0, 24, 0, 0);
      vecs[5] = mk("oversize", 2, 500, 2000, 2500, 10, 0, 0,     2, 500, 2000, 2500, 10);
      vecs[6] = mk("zero_len", 2, 0, 0, 0, 5, 0, 0,              1, 0, 5, 0, 0);
      vecs[7] = mk("fit1460",  2, 10, 700, 710, 760, 0, 0,       1, 10, 1460, 0, 0);
      vecs[8] = mk("fit1461",  2, 10, 700, 710, 761, 0, 0,       2, 10, 700, 710, 761);
      vecs[9] = mk("mid_gap",  3, 5, 5, 10, 5, 30, 5,            2, 5, 10, 30, 5);

      #12;
      check("rst_seg_val", 64'(seg_val), 64'd0);
      check("rst_seg_seq", 64'(seg_seq), 64'd0);
      check("rst_seg_len", 64'(seg_len), 64'd0);
      check("rst_rd_req",  64'(fifo_rd_req), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int v = 0; v < 10; v++) begin
         got_q.delete();
         for (int k = 0; k < vecs[v].n_in; k++) push(vecs[v].iseq[k], vecs[v].ilen[k]);
         drain();
         check({vecs[v].name, "_count"}, 64'(got_q.size()), 64'(vecs[v].n_out));
         for (int j = 0; j < vecs[v].n_out; j++) begin
            if (j < got_q.size()) begin
               check({vecs[v].name, "_seq"}, 64'(got_q[j].seq), 64'(vecs[v].oseq[j]));
               check({vecs[v].name, "_len"}, 64'(got_q[j].len), 64'(vecs[v].olen[j]));
            end
         end
      end

      // Pure timeout: seg_val rises on the 65th edge counting the last pop edge as the first.
      got_q.delete();
      push(100, 10); push(110, 20); push(130, 5);
      seen = 1'b0;
      gap  = 0;
      for (int n = 0; n < 200 && !seen; n++) begin
         step();
         if (seg_val) begin
            seen = 1'b1;
            gap  = edges_since_pop;
         end
      end
      check("timeout_seen", 64'(seen), 64'd1);
      check("timeout_edges", 64'(gap), 64'd65);
      check("timeout_seg_len", 64'(seg_len), 64'd35);
      drain();

      // Back-to-back, backpressure and flush.
      got_q.delete();
      push(100, 10); push(200, 10);
      step();
      check("b2b_load_val", 64'(seg_val), 64'd0);
      check("b2b_load_cnt", 64'(fifo_num_els), 64'd1);
      seg_rdy = 1'b0;
      push(300, 10);
      step();
      check("gap_out_val", 64'(seg_val), 64'd1);
      check("gap_out_seq", 64'(seg_seq), 64'd100);
      check("gap_out_len", 64'(seg_len), 64'd10);
      for (int n = 0; n < 10; n++) begin
         #1;
         check("bp_no_pop", 64'(fifo_rd_req), 64'd0);
         step();
         check("bp_val", 64'(seg_val), 64'd1);
         check("bp_seg", 64'({seg_seq, seg_len}), 64'({32'd100, 16'd10}));
         check("bp_cnt", 64'(fifo_num_els), 64'd2);
      end
      seg_rdy = 1'b1;
      #1;
      check("rdy_pop_req", 64'(fifo_rd_req), 64'd1);
      step();
      check("rdy_loaded_val", 64'(seg_val), 64'd0);
      check("rdy_loaded_cnt", 64'(fifo_num_els), 64'd1);
      check("rdy_xfer_count", 64'(got_q.size()), 64'd1);
      step();
      check("second_out_val", 64'(seg_val), 64'd1);
      check("second_out_seg", 64'({seg_seq, seg_len}), 64'({32'd200, 16'd10}));
      step();
      check("third_load_val", 64'(seg_val), 64'd0);
      check("third_load_cnt", 64'(fifo_num_els), 64'd0);
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("flush_val", 64'(seg_val), 64'd1);
      check("flush_seg", 64'({seg_seq, seg_len}), 64'({32'd300, 16'd10}));
      drain();
      check("bp_total_segs", 64'(got_q.size()), 64'd3);

      // Asynchronous reset mid-ACCUM discards the accumulator.
      got_q.delete();
      push(50, 5);
      step();
      push(55, 5);
      #1;
      check("pre_rst_req", 64'(fifo_rd_req), 64'd1);
      check("pre_rst_len", 64'(seg_len), 64'd5);
      #1;
      rst_n = 1'b0;
      #1;
      check("async_rst_val", 64'(seg_val), 64'd0);
      check("async_rst_len", 64'(seg_len), 64'd0);
      check("async_rst_seq", 64'(seg_seq), 64'd0);
      check("async_rst_req", 64'(fifo_rd_req), 64'd0);
      step();
      check("rst_hold_cnt", 64'(fifo_num_els), 64'd1);
      rst_n = 1'b1;
      drain();
      check("post_rst_count", 64'(got_q.size()), 64'd1);
      if (got_q.size() > 0) begin
         check("post_rst_seq", 64'(got_q[0].seq), 64'd55);
         check("post_rst_len", 64'(got_q[0].len), 64'd5);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
